// File: rtl/lu_row_mem_pkg.sv
// Shared types and defaults for the LU row memory and its clients.
// Elements are {imag, real} IEEE-754 double bit patterns, real in the low half.
package lu_pkg;

    localparam int unsigned SIZE_DEF  = 4;
    localparam int unsigned WIDTH_DEF = 64;

    typedef struct packed {
        logic [WIDTH_DEF-1:0] im;
        logic [WIDTH_DEF-1:0] re;
    } complex_t;

    typedef complex_t [SIZE_DEF-1:0] row_t;

    typedef enum logic [1:0] {
        MS_LOAD  = 2'd0,
        MS_READY = 2'd1,
        MS_RUN   = 2'd2
    } mem_state_e;

endpackage

// File: rtl/lu_row_mem_if.sv
// Engine-side row read / write-back bus between the lu core (master) and lu_row_mem (slave).
interface lu_row_mem_if
    import lu_pkg::*;
#(
    parameter int unsigned SIZE  = SIZE_DEF,
    parameter int unsigned WIDTH = WIDTH_DEF
);
    localparam int unsigned AW    = $clog2(SIZE);
    localparam int unsigned ROW_W = SIZE * 2 * WIDTH;

    logic [AW-1:0]    mat_row_read_addr_i;
    logic             mat_row_read_addr_valid_i;
    logic [ROW_W-1:0] mat_row_o;
    logic [AW-1:0]    mat_row_addr_o;
    logic             mat_row_valid_o;
    logic [ROW_W-1:0] mat_row_wb_i;
    logic [AW-1:0]    mat_row_wb_addr_i;
    logic             mat_row_wb_valid_i;
    logic             mat_row_wb_ready_o;

    modport master (
        output mat_row_read_addr_i,
        output mat_row_read_addr_valid_i,
        input  mat_row_o,
        input  mat_row_addr_o,
        input  mat_row_valid_o,
        output mat_row_wb_i,
        output mat_row_wb_addr_i,
        output mat_row_wb_valid_i,
        input  mat_row_wb_ready_o
    );

    modport slave (
        input  mat_row_read_addr_i,
        input  mat_row_read_addr_valid_i,
        output mat_row_o,
        output mat_row_addr_o,
        output mat_row_valid_o,
        input  mat_row_wb_i,
        input  mat_row_wb_addr_i,
        input  mat_row_wb_valid_i,
        output mat_row_wb_ready_o
    );

endinterface

// File: rtl/lu_row_mem_port.sv
// One registered row read port: 1-cycle latency, write-first forwarding,
// unloaded rows read back as zero and raise a miss in the request cycle.
module lu_row_mem_port
    import lu_pkg::*;
#(
    parameter int unsigned SIZE  = SIZE_DEF,
    parameter int unsigned WIDTH = WIDTH_DEF,
    localparam int unsigned AW    = $clog2(SIZE),
    localparam int unsigned ROW_W = SIZE * 2 * WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             rd_valid_i,
    input  logic [AW-1:0]    rd_addr_i,
    input  logic [ROW_W-1:0] stored_row_i,
    input  logic             stored_vld_i,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [ROW_W-1:0] wr_row_i,
    output logic [ROW_W-1:0] rd_row_o,
    output logic             rd_valid_o,
    output logic             miss_o
);
    logic             fwd;
    logic [ROW_W-1:0] row_d, row_q;
    logic             valid_d, valid_q;

    always_comb begin
        fwd     = wr_en_i && (wr_addr_i == rd_addr_i);
        miss_o  = rd_valid_i && !fwd && !stored_vld_i;
        valid_d = rd_valid_i;
        row_d   = '0;
        if (rd_valid_i) begin
            if (fwd) begin
                row_d = wr_row_i;
            end else if (stored_vld_i) begin
                row_d = stored_row_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            row_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            row_q   <= row_d;
            valid_q <= valid_d;
        end
    end

    assign rd_row_o   = row_q;
    assign rd_valid_o = valid_q;

endmodule

// File: rtl/lu_row_mem.sv
// Row-organised complex matrix store shared by the host loader and the LU engine,
// with a LOAD/READY/RUN ownership FSM and a sticky unloaded-read error.
module lu_row_mem
    import lu_pkg::*;
#(
    parameter int unsigned SIZE  = SIZE_DEF,
    parameter int unsigned WIDTH = WIDTH_DEF,
    localparam int unsigned AW    = $clog2(SIZE),
    localparam int unsigned ROW_W = SIZE * 2 * WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             host_wr_valid_i,
    input  logic [AW-1:0]    host_wr_addr_i,
    input  logic [ROW_W-1:0] host_wr_row_i,
    output logic             host_wr_ready_o,
    input  logic             host_rd_valid_i,
    input  logic [AW-1:0]    host_rd_addr_i,
    output logic [ROW_W-1:0] host_rd_row_o,
    output logic             host_rd_valid_o,
    input  logic             clear_i,
    input  logic             lock_i,
    output logic             full_o,
    output logic             err_o,
    lu_row_mem_if.slave      eng
);
    localparam logic [1:0] ST_LOAD  = MS_LOAD;
    localparam logic [1:0] ST_READY = MS_READY;
    localparam logic [1:0] ST_RUN   = MS_RUN;

    logic [1:0]       state_d, state_q;
    logic [ROW_W-1:0] mem_d [SIZE];
    logic [ROW_W-1:0] mem_q [SIZE];
    logic [SIZE-1:0]  vld_d, vld_q;
    logic             full_d, full_q;
    logic             err_d, err_q;
    logic [AW-1:0]    eng_addr_d, eng_addr_q;

    logic             host_wr_ready;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [ROW_W-1:0] wr_row;
    logic             eng_miss, host_miss;
    logic [ROW_W-1:0] eng_row, host_row;
    logic             eng_valid, host_valid;

    // Single write port: engine write-back wins, host is held off while it writes.
    always_comb begin
        host_wr_ready = (state_q != ST_RUN) && !eng.mat_row_wb_valid_i;
        wr_en         = 1'b0;
        wr_addr       = eng.mat_row_wb_addr_i;
        wr_row        = eng.mat_row_wb_i;
        if (eng.mat_row_wb_valid_i) begin
            wr_en = 1'b1;
        end else if (host_wr_valid_i && host_wr_ready) begin
            wr_en   = 1'b1;
            wr_addr = host_wr_addr_i;
            wr_row  = host_wr_row_i;
        end
    end

    always_comb begin
        mem_d = mem_q;
        vld_d = vld_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_row;
            vld_d[wr_addr] = 1'b1;
        end
        if (clear_i) begin
            vld_d = '0;
        end
        full_d     = &vld_d;
        err_d      = clear_i ? 1'b0 : (err_q | eng_miss | host_miss);
        eng_addr_d = eng.mat_row_read_addr_valid_i ? eng.mat_row_read_addr_i : '0;

        state_d = state_q;
        if (clear_i) begin
            state_d = ST_LOAD;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (lock_i) begin
                        state_d = ST_RUN;
                    end else if (full_d) begin
                        state_d = ST_READY;
                    end
                end
                ST_READY: begin
                    if (lock_i) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    // A run started from LOAD may release with rows still missing.
                    if (!lock_i) begin
                        state_d = full_d ? ST_READY : ST_LOAD;
                    end
                end
                default: state_d = ST_LOAD;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < SIZE; i++) begin
                mem_q[i] <= '0;
            end
            vld_q      <= '0;
            full_q     <= 1'b0;
            err_q      <= 1'b0;
            eng_addr_q <= '0;
            state_q    <= ST_LOAD;
        end else begin
            mem_q      <= mem_d;
            vld_q      <= vld_d;
            full_q     <= full_d;
            err_q      <= err_d;
            eng_addr_q <= eng_addr_d;
            state_q    <= state_d;
        end
    end

    lu_row_mem_port #(.SIZE(SIZE), .WIDTH(WIDTH)) u_eng_port (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .rd_valid_i   (eng.mat_row_read_addr_valid_i),
        .rd_addr_i    (eng.mat_row_read_addr_i),
        .stored_row_i (mem_q[eng.mat_row_read_addr_i]),
        .stored_vld_i (vld_q[eng.mat_row_read_addr_i]),
        .wr_en_i      (wr_en),
        .wr_addr_i    (wr_addr),
        .wr_row_i     (wr_row),
        .rd_row_o     (eng_row),
        .rd_valid_o   (eng_valid),
        .miss_o       (eng_miss)
    );

    lu_row_mem_port #(.SIZE(SIZE), .WIDTH(WIDTH)) u_host_port (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .rd_valid_i   (host_rd_valid_i),
        .rd_addr_i    (host_rd_addr_i),
        .stored_row_i (mem_q[host_rd_addr_i]),
        .stored_vld_i (vld_q[host_rd_addr_i]),
        .wr_en_i      (wr_en),
        .wr_addr_i    (wr_addr),
        .wr_row_i     (wr_row),
        .rd_row_o     (host_row),
        .rd_valid_o   (host_valid),
        .miss_o       (host_miss)
    );

    assign host_wr_ready_o        = host_wr_ready;
    assign host_rd_row_o          = host_row;
    assign host_rd_valid_o        = host_valid;
    assign full_o                 = full_q;
    assign err_o                  = err_q;
    assign eng.mat_row_o          = eng_row;
    assign eng.mat_row_addr_o     = eng_addr_q;
    assign eng.mat_row_valid_o    = eng_valid;
    assign eng.mat_row_wb_ready_o = 1'b1;

endmodule

// File: tb/tb_lu_row_mem.sv
// Directed plus randomized bench for lu_row_mem against a row-level reference model.
module tb_lu_row_mem;
    import lu_pkg::*;

    localparam int unsigned SIZE  = SIZE_DEF;
    localparam int unsigned WIDTH = WIDTH_DEF;
    localparam int unsigned AW    = $clog2(SIZE);
    localparam int unsigned ROW_W = SIZE * 2 * WIDTH;
    localparam logic [WIDTH-1:0] ONE = 64'h3FF0000000000000;
    localparam logic [WIDTH-1:0] TWO = 64'h4000000000000000;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             host_wr_valid_i;
    logic [AW-1:0]    host_wr_addr_i;
    logic [ROW_W-1:0] host_wr_row_i;
    logic             host_wr_ready_o;
    logic             host_rd_valid_i;
    logic [AW-1:0]    host_rd_addr_i;
    logic [ROW_W-1:0] host_rd_row_o;
    logic             host_rd_valid_o;
    logic             clear_i;
    logic             lock_i;
    logic             full_o;
    logic             err_o;

    lu_row_mem_if #(.SIZE(SIZE), .WIDTH(WIDTH)) eng ();

    lu_row_mem #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .host_wr_valid_i (host_wr_valid_i),
        .host_wr_addr_i  (host_wr_addr_i),
        .host_wr_row_i   (host_wr_row_i),
        .host_wr_ready_o (host_wr_ready_o),
        .host_rd_valid_i (host_rd_valid_i),
        .host_rd_addr_i  (host_rd_addr_i),
        .host_rd_row_o   (host_rd_row_o),
        .host_rd_valid_o (host_rd_valid_o),
        .clear_i         (clear_i),
        .lock_i          (lock_i),
        .full_o          (full_o),
        .err_o           (err_o),
        .eng             (eng)
    );

    always #5 clk_i = ~clk_i;

    int errors;
    int checks;

    // Reference model: matrix contents, loaded-row set, engine ownership, flags.
    logic [ROW_W-1:0] m_mem [SIZE];
    logic [SIZE-1:0]  m_vld;
    logic             m_run;
    logic             m_err;

    task automatic check_row(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    function automatic logic [ROW_W-1:0] rand_row();
        logic [ROW_W-1:0] r;
        for (int k = 0; k < int'(ROW_W / 32); k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [ROW_W-1:0] diag_row(input int unsigned idx, input logic [WIDTH-1:0] val);
        logic [ROW_W-1:0] r;
        complex_t c;
        r = '0;
        c.im = '0;
        c.re = val;
        r[idx*2*WIDTH +: 2*WIDTH] = c;
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < int'(SIZE); i++) m_mem[i] = '0;
        m_vld = '0;
        m_run = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic idle_inputs();
        host_wr_valid_i               = 1'b0;
        host_rd_valid_i               = 1'b0;
        clear_i                       = 1'b0;
        eng.mat_row_read_addr_valid_i = 1'b0;
        eng.mat_row_wb_valid_i        = 1'b0;
    endtask

    // Called at a falling edge with this cycle's inputs applied; checks the
    // combinational handshakes, advances one clock and checks the responses.
    task automatic do_cycle();
        logic             wb, hw, wen, e_req, h_req, e_hit, h_hit, e_miss, h_miss;
        logic [AW-1:0]    wa, e_addr, h_addr;
        logic [ROW_W-1:0] wd, e_row, h_row;
        #1;
        wb = eng.mat_row_wb_valid_i;
        hw = host_wr_valid_i && !m_run && !wb;
        check_bit("host_wr_ready", host_wr_ready_o, !m_run && !wb);
        check_bit("wb_ready", eng.mat_row_wb_ready_o, 1'b1);
        wen    = wb || hw;
        wa     = wb ? eng.mat_row_wb_addr_i : host_wr_addr_i;
        wd     = wb ? eng.mat_row_wb_i : host_wr_row_i;
        e_req  = eng.mat_row_read_addr_valid_i;
        e_addr = eng.mat_row_read_addr_i;
        h_req  = host_rd_valid_i;
        h_addr = host_rd_addr_i;
        e_hit  = wen && (wa == e_addr);
        h_hit  = wen && (wa == h_addr);
        e_row  = e_hit ? wd : (m_vld[e_addr] ? m_mem[e_addr] : '0);
        h_row  = h_hit ? wd : (m_vld[h_addr] ? m_mem[h_addr] : '0);
        e_miss = e_req && !e_hit && !m_vld[e_addr];
        h_miss = h_req && !h_hit && !m_vld[h_addr];
        if (wen) begin
            m_mem[wa] = wd;
            m_vld[wa] = 1'b1;
        end
        if (clear_i) m_vld = '0;
        m_err = clear_i ? 1'b0 : (m_err | e_miss | h_miss);
        m_run = lock_i && !clear_i;
        @(posedge clk_i);
        @(negedge clk_i);
        check_bit("eng_valid", eng.mat_row_valid_o, e_req);
        if (e_req) begin
            check_row("eng_addr", ROW_W'(eng.mat_row_addr_o), ROW_W'(e_addr));
            check_row("eng_row", eng.mat_row_o, e_row);
        end
        check_bit("host_rd_valid", host_rd_valid_o, h_req);
        if (h_req) check_row("host_row", host_rd_row_o, h_row);
        check_bit("full", full_o, &m_vld);
        check_bit("err", err_o, m_err);
        idle_inputs();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_bit({tag, "_host_wr_ready"}, host_wr_ready_o, 1'b1);
        check_bit({tag, "_wb_ready"}, eng.mat_row_wb_ready_o, 1'b1);
        check_bit({tag, "_eng_valid"}, eng.mat_row_valid_o, 1'b0);
        check_row({tag, "_eng_row"}, eng.mat_row_o, '0);
        check_row({tag, "_eng_addr"}, ROW_W'(eng.mat_row_addr_o), '0);
        check_bit({tag, "_host_rd_valid"}, host_rd_valid_o, 1'b0);
        check_row({tag, "_host_row"}, host_rd_row_o, '0);
        check_bit({tag, "_full"}, full_o, 1'b0);
        check_bit({tag, "_err"}, err_o, 1'b0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_i  = 1'b1;
        lock_i = 1'b0;
        host_wr_addr_i            = '0;
        host_wr_row_i             = '0;
        host_rd_addr_i            = '0;
        eng.mat_row_read_addr_i   = '0;
        eng.mat_row_wb_i          = '0;
        eng.mat_row_wb_addr_i     = '0;
        idle_inputs();
        model_reset();
        #2;
        check_reset_outputs("reset");
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Load an identity matrix; full rises only after the last row.
        for (int i = 0; i < int'(SIZE); i++) begin
            host_wr_valid_i = 1'b1;
            host_wr_addr_i  = AW'(i);
            host_wr_row_i   = diag_row(i, ONE);
            do_cycle();
        end
        check_bit("full_after_load", full_o, 1'b1);

        lock_i = 1'b1;
        do_cycle();
        for (int i = int'(SIZE) - 1; i >= 0; i--) begin
            eng.mat_row_read_addr_valid_i = 1'b1;
            eng.mat_row_read_addr_i       = AW'(i);
            do_cycle();
        end

        // Host write blocked in RUN while engine writes back 2.0 to the same row.
        host_wr_valid_i        = 1'b1;
        host_wr_addr_i         = AW'(1);
        host_wr_row_i          = rand_row();
        eng.mat_row_wb_valid_i = 1'b1;
        eng.mat_row_wb_addr_i  = AW'(1);
        eng.mat_row_wb_i       = diag_row(1, TWO);
        do_cycle();
        eng.mat_row_read_addr_valid_i = 1'b1;
        eng.mat_row_read_addr_i       = AW'(1);
        do_cycle();
        check_row("row1_two", eng.mat_row_o, diag_row(1, TWO));

        // Same-cycle engine read and write-back of row 2 forwards the new data.
        eng.mat_row_read_addr_valid_i = 1'b1;
        eng.mat_row_read_addr_i       = AW'(2);
        eng.mat_row_wb_valid_i        = 1'b1;
        eng.mat_row_wb_addr_i         = AW'(2);
        eng.mat_row_wb_i              = rand_row();
        do_cycle();

        // Host read in RUN forwarded from a write-back to the same row.
        host_rd_valid_i        = 1'b1;
        host_rd_addr_i         = AW'(3);
        eng.mat_row_wb_valid_i = 1'b1;
        eng.mat_row_wb_addr_i  = AW'(3);
        eng.mat_row_wb_i       = rand_row();
        do_cycle();

        lock_i = 1'b0;
        for (int n = 0; n < 80; n++) begin
            lock_i                        = 1'($urandom_range(0, 1));
            host_wr_valid_i               = 1'($urandom_range(0, 1));
            host_wr_addr_i                = AW'($urandom_range(0, SIZE - 1));
            host_wr_row_i                 = rand_row();
            eng.mat_row_wb_valid_i        = ($urandom_range(0, 3) == 0);
            eng.mat_row_wb_addr_i         = AW'($urandom_range(0, SIZE - 1));
            eng.mat_row_wb_i              = rand_row();
            eng.mat_row_read_addr_valid_i = 1'($urandom_range(0, 1));
            eng.mat_row_read_addr_i       = AW'($urandom_range(0, SIZE - 1));
            host_rd_valid_i               = 1'($urandom_range(0, 1));
            host_rd_addr_i                = AW'($urandom_range(0, SIZE - 1));
            do_cycle();
        end

        // Clear beats lock; next cycle still accepts host writes (state LOAD).
        lock_i  = 1'b1;
        clear_i = 1'b1;
        do_cycle();
        check_bit("full_after_clear", full_o, 1'b0);
        eng.mat_row_read_addr_valid_i = 1'b1;
        eng.mat_row_read_addr_i       = AW'(0);
        do_cycle();
        check_row("unloaded_row_zero", eng.mat_row_o, '0);
        lock_i = 1'b0;
        do_cycle();
        do_cycle();
        check_bit("err_sticky", err_o, 1'b1);

        // Asynchronous reset while a response is on the bus.
        eng.mat_row_read_addr_valid_i = 1'b1;
        eng.mat_row_read_addr_i       = AW'(2);
        @(posedge clk_i);
        #1;
        check_bit("pre_reset_valid", eng.mat_row_valid_o, 1'b1);
        idle_inputs();
        rst_i = 1'b1;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk_i);
        rst_i = 1'b0;
        model_reset();
        do_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lu_row_mem.md
# lu_row_mem

Row-organised complex matrix store that answers the LU engine's row read requests and absorbs its row write-backs. It sits between the host/loader and the `lu` core and holds SIZE rows of SIZE complex elements. Each element is {imag[WIDTH], real[WIDTH]} in IEEE-754 double bits. A load/run state machine gates host access while the engine owns the matrix, and flags reads of rows that were never loaded.

## Interface
- SIZE, 4, matrix dimension (rows and elements per row), power of two ≥2
- WIDTH, 64, bits per real/imag component
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- host_wr_valid_i  in  1  host row write request
- host_wr_addr_i  in  $clog2(SIZE)  host write row index
- host_wr_row_i  in  SIZE*2*WIDTH  host write data; element j at [j*2*WIDTH +: 2*WIDTH], real in the low half
- host_wr_ready_o  out  1  host write accepted this cycle
- host_rd_valid_i  in  1  host row read request
- host_rd_addr_i  in  $clog2(SIZE)  host read row index
- host_rd_row_o  out  SIZE*2*WIDTH  host read data
- host_rd_valid_o  out  1  host read data valid
- clear_i  in  1  synchronous clear of the row-valid bitmap
- lock_i  in  1  engine owns matrix (driven from engine busy)
- full_o  out  1  all SIZE rows loaded
- mat_row_read_addr_i  in  $clog2(SIZE)  engine read row index
- mat_row_read_addr_valid_i  in  1  engine read request
- mat_row_o  out  SIZE*2*WIDTH  read response row
- mat_row_addr_o  out  $clog2(SIZE)  echoed row index of the response
- mat_row_valid_o  out  1  read response valid
- mat_row_wb_i  in  SIZE*2*WIDTH  engine write-back row
- mat_row_wb_addr_i  in  $clog2(SIZE)  write-back row index
- mat_row_wb_valid_i  in  1  write-back request
- mat_row_wb_ready_o  out  1  write-back accepted
- err_o  out  1  sticky: a read hit an unloaded row

## Operation
- Storage is mem[SIZE] × SIZE*2*WIDTH bits, plus a valid bitmap vld[SIZE].
- States:
  - LOAD: entered on reset or clear_i.
  - READY: entered when vld is all ones.
  - RUN: entered from READY when lock_i=1.
  - RUN → READY when lock_i falls.
  - lock_i asserted in LOAD moves to RUN; err_o then reports any unloaded reads.
- Host writes:
  - host_wr_ready_o = (state≠RUN) & ~mat_row_wb_valid_i.
  - An accepted write updates mem and sets vld[addr].
- Engine write-backs:
  - mat_row_wb_ready_o = 1 in every state; engine write-back has priority over host writes.
  - An accepted write-back sets vld[addr].
- Engine reads:
  - No backpressure; one response per request.
  - A read of a row with vld=0 returns all zeros and sets err_o.
- Host reads are served in every state, including RUN.
- Same-cycle read and write to the same row: the read returns the new data (write-first forwarding). This applies to both read ports.
- clear_i zeroes vld, enters LOAD, and clears err_o; mem contents are retained.
- clear_i has priority over lock_i.
- full_o = &vld, registered.

## Timing
- Reset values:
  - All outputs 0, except mat_row_wb_ready_o = 1 and host_wr_ready_o = 1.
  - mem and vld zeroed; state LOAD.
- Read latency is exactly 1 cycle on both ports. A request in cycle N produces the response in cycle N+1 with data, address echo and valid registered.
- Back-to-back reads every cycle are sustained.
- Write data is visible to a read in the same cycle (forwarded) and in later cycles.
- full_o and the state update one cycle after the write that completes the bitmap.
- If reset is asserted mid-RUN, in-flight responses are dropped and mat_row_valid_o falls immediately (asynchronous reset).

## Structure
- Shared package `lu_pkg`:
  - complex_t: {logic [WIDTH-1:0] im, re}
  - row_t: complex_t [SIZE-1:0]
  - mem_state_e: LOAD/READY/RUN
  - SIZE_DEF / WIDTH_DEF constants
- One sub-module, `lu_row_mem_port`: 1-cycle registered read with write-first forwarding. It is instantiated twice, once for the engine port and once for the host port.

## Test plan
- Load rows 0..3 with host writes of diagonal value 1.0 (0x3FF0000000000000) → full_o=1 in the cycle after the 4th write; state READY.
- lock_i=1, then engine reads addresses 3,2,1,0 back-to-back → mat_row_valid_o=1 for 4 cycles, echoed addresses 3,2,1,0, data matching the loaded rows.
- In RUN, host write to row 1 together with an engine write-back to row 1 with value 2.0 → host_wr_ready_o=0; row 1 reads 0x4000000000000000.
- Engine read and write-back to row 2 in the same cycle → the response carries the write-back data.
- After clear_i, engine read of row 0 → mat_row_o=0 and err_o=1 (sticky until the next clear_i).
- Assert rst_i mid-stream of reads → all outputs return to reset values at once; full_o=0.
